// File: rtl/pwm_ctrl_pkg.sv
// Shared types and widths for the PWM duty-ramp path (deserializer -> ramp ctrl -> spi_peripheral).
package pwm_ctrl_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam logic [ADDR_W-1:0] DUTY_ADDR_DEF = 7'h04;

  typedef enum logic [1:0] {IDLE, WAIT, WRITE} ramp_state_e;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_txn_t;

  // One ramp step from cur toward target, clamped at target (9-bit math, no wrap).
  function automatic logic [DATA_W-1:0] ramp_next(input logic [DATA_W-1:0] cur,
                                                  input logic [DATA_W-1:0] step,
                                                  input logic [DATA_W-1:0] target);
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    if (target > cur) begin
      return (sum >= {1'b0, target}) ? target : sum[DATA_W-1:0];
    end
    return (diff[DATA_W] || (diff[DATA_W-1:0] <= target)) ? target : diff[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/ramp_tick_timer.sv
// Loadable down-counter that paces the idle gap between ramp steps.
module ramp_tick_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps the PWM duty register toward a target, sharing the register-write port with SPI.
// Build option PWM_RAMP_OVERRIDE_EN: an SPI duty write while busy aborts the ramp.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DUTY_ADDR  = DUTY_ADDR_DEF,
  parameter int unsigned       INTERVAL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_valid,
  input  logic                  spi_rw,
  input  logic [ADDR_W-1:0]     spi_addr,
  input  logic [DATA_W-1:0]     spi_data,
  input  logic                  ramp_start,
  input  logic [DATA_W-1:0]     ramp_target,
  input  logic [DATA_W-1:0]     ramp_step,
  input  logic [INTERVAL_W-1:0] ramp_interval,
  output logic                  wr_valid,
  output logic                  wr_rw,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     duty_cur,
  output logic                  busy,
  output logic                  done
);

  ramp_state_e           state, state_d;
  wr_txn_t               wr_q, wr_d;
  logic                  wr_valid_d, done_d, busy_d;
  logic [DATA_W-1:0]     duty_d, tgt_q, tgt_d, step_q, step_d, next_val;
  logic [INTERVAL_W-1:0] ival_q, ival_d, tmr_val;
  logic                  prime_q, prime_d, tmr_load, tmr_dec, tmr_zero_c, spi_duty_wr;

  ramp_tick_timer #(.W(INTERVAL_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero_c   (tmr_zero_c)
  );

  assign spi_duty_wr = spi_valid && spi_rw && (spi_addr == DUTY_ADDR);
  assign next_val    = ramp_next(duty_cur, step_q, tgt_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // prime_q adds one settle cycle before the first step of a ramp.
  always_comb begin
    state_d    = state;
    wr_d       = wr_q;
    wr_valid_d = 1'b0;
    duty_d     = duty_cur;
    done_d     = 1'b0;
    tgt_d      = tgt_q;
    step_d     = step_q;
    ival_d     = ival_q;
    prime_d    = prime_q;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    tmr_val    = ival_q;

    if (spi_valid) begin
      wr_valid_d = 1'b1;
      wr_d       = '{rw: spi_rw, addr: spi_addr, data: spi_data};
      if (spi_duty_wr) duty_d = spi_data;
    end

    case (state)
      WAIT: begin
        if (!tmr_zero_c)  tmr_dec = 1'b1;
        else if (prime_q) prime_d = 1'b0;
        else              state_d = WRITE;
      end
      WRITE: begin
        if (!spi_valid && !ramp_start) begin
          wr_valid_d = 1'b1;
          wr_d       = '{rw: 1'b1, addr: DUTY_ADDR, data: next_val};
          duty_d     = next_val;
          if (next_val == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = WAIT;
            tmr_load = 1'b1;
          end
        end
      end
      default: ;
    endcase

`ifdef PWM_RAMP_OVERRIDE_EN
    if (spi_duty_wr && (state != IDLE)) state_d = IDLE;
`endif

    // A new start always wins and silently abandons any ramp in flight.
    if (ramp_start) begin
      tgt_d   = ramp_target;
      step_d  = (ramp_step == '0) ? DATA_W'(1) : ramp_step;
      ival_d  = ramp_interval;
      prime_d = 1'b1;
      if (duty_cur == ramp_target) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d  = WAIT;
        tmr_load = 1'b1;
        tmr_val  = ramp_interval;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= '0;
      wr_valid <= 1'b0;
      duty_cur <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tgt_q    <= '0;
      step_q   <= '0;
      ival_q   <= '0;
      prime_q  <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      wr_valid <= wr_valid_d;
      duty_cur <= duty_d;
      busy     <= busy_d;
      done     <= done_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      ival_q   <= ival_d;
      prime_q  <= prime_d;
    end
  end

  assign wr_rw   = wr_q.rw;
  assign wr_addr = wr_q.addr;
  assign wr_data = wr_q.data;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: ramps, collision, equal target, mid-ramp SPI, reset.
module tb_pwm_ramp_ctrl;

  localparam int unsigned IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          spi_valid, spi_rw;
  logic [6:0]    spi_addr;
  logic [7:0]    spi_data;
  logic          ramp_start;
  logic [7:0]    ramp_target, ramp_step;
  logic [IW-1:0] ramp_interval;
  logic          wr_valid, wr_rw, busy, done;
  logic [6:0]    wr_addr;
  logic [7:0]    wr_data, duty_cur;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .spi_valid     (spi_valid),
    .spi_rw        (spi_rw),
    .spi_addr      (spi_addr),
    .spi_data      (spi_data),
    .ramp_start    (ramp_start),
    .ramp_target   (ramp_target),
    .ramp_step     (ramp_step),
    .ramp_interval (ramp_interval),
    .wr_valid      (wr_valid),
    .wr_rw         (wr_rw),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .duty_cur      (duty_cur),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    spi_valid  = 1'b0;
    ramp_start = 1'b0;
  endtask

  task automatic spi(input logic rw, input logic [6:0] a, input logic [7:0] d);
    spi_valid = 1'b1;
    spi_rw    = rw;
    spi_addr  = a;
    spi_data  = d;
  endtask

  task automatic start(input logic [7:0] t, input logic [7:0] s, input logic [IW-1:0] iv);
    ramp_start    = 1'b1;
    ramp_target   = t;
    ramp_step     = s;
    ramp_interval = iv;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(wr_valid), 32'd0);
    chk({tag, "_rw"},    32'(wr_rw),    32'd0);
    chk({tag, "_addr"},  32'(wr_addr),  32'd0);
    chk({tag, "_data"},  32'(wr_data),  32'd0);
    chk({tag, "_duty"},  32'(duty_cur), 32'd0);
    chk({tag, "_busy"},  32'(busy),     32'd0);
    chk({tag, "_done"},  32'(done),     32'd0);
  endtask

  initial begin
    rst = 1'b1;
    spi_valid = 1'b0; spi_rw = 1'b0; spi_addr = '0; spi_data = '0;
    ramp_start = 1'b0; ramp_target = '0; ramp_step = '0; ramp_interval = '0;
    tick(); tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Up ramp 0 -> 10, step 4, interval 0: writes 4, 8, 10 at cycles 3, 5, 7.
    start(8'd10, 8'd4, 16'd0);
    for (int k = 0; k <= 8; k++) begin
      tick();
      clr();
      chk("up_valid", 32'(wr_valid), 32'((k == 3) || (k == 5) || (k == 7)));
      chk("up_done",  32'(done),     32'(k == 7));
      chk("up_busy",  32'(busy),     32'(k < 7));
      if (k == 3) chk("up_d4",  32'(wr_data), 32'd4);
      if (k == 5) chk("up_d8",  32'(wr_data), 32'd8);
      if (k == 7) begin
        chk("up_d10",   32'(wr_data), 32'd10);
        chk("up_addr",  32'(wr_addr), 32'h04);
        chk("up_rw",    32'(wr_rw),   32'd1);
      end
    end
    chk("up_duty", 32'(duty_cur), 32'd10);

    // SPI read passes through unchanged and does not touch duty_cur.
    spi(1'b0, 7'h12, 8'h34);
    tick(); clr();
    chk("rd_valid", 32'(wr_valid), 32'd1);
    chk("rd_rw",    32'(wr_rw),    32'd0);
    chk("rd_addr",  32'(wr_addr),  32'h12);
    chk("rd_data",  32'(wr_data),  32'h34);
    chk("rd_duty",  32'(duty_cur), 32'd10);

    // SPI write to duty register sets duty_cur to 200.
    spi(1'b1, 7'h04, 8'd200);
    tick(); clr();
    chk("wr_valid", 32'(wr_valid), 32'd1);
    chk("wr_data",  32'(wr_data),  32'd200);
    chk("wr_duty",  32'(duty_cur), 32'd200);

    // Down ramp 200 -> 0, step 100, interval 5: writes 100, 0 at cycles 8, 15.
    start(8'd0, 8'd100, 16'd5);
    for (int k = 0; k <= 16; k++) begin
      tick();
      clr();
      chk("dn_valid", 32'(wr_valid), 32'((k == 8) || (k == 15)));
      chk("dn_done",  32'(done),     32'(k == 15));
      if (k == 8)  chk("dn_d100", 32'(wr_data), 32'd100);
      if (k == 15) chk("dn_d0",   32'(wr_data), 32'd0);
    end
    chk("dn_duty", 32'(duty_cur), 32'd0);
    chk("dn_busy", 32'(busy),     32'd0);

    // Collision: SPI wins on the WRITE cycle, ramp write follows one cycle later.
    start(8'd3, 8'd5, 16'd0);
    tick(); clr();
    tick(); tick();
    spi(1'b1, 7'h00, 8'h5A);
    tick(); clr();
    chk("col_spi_valid", 32'(wr_valid), 32'd1);
    chk("col_spi_addr",  32'(wr_addr),  32'h00);
    chk("col_spi_data",  32'(wr_data),  32'h5A);
    chk("col_duty_hold", 32'(duty_cur), 32'd0);
    tick();
    chk("col_rmp_valid", 32'(wr_valid), 32'd1);
    chk("col_rmp_addr",  32'(wr_addr),  32'h04);
    chk("col_rmp_data",  32'(wr_data),  32'd3);
    chk("col_rmp_done",  32'(done),     32'd1);

    // Target equals duty_cur: done only, no write, never busy.
    spi(1'b1, 7'h04, 8'h55);
    tick(); clr();
    tick();
    start(8'h55, 8'd1, 16'd3);
    tick(); clr();
    chk("eq_done",  32'(done),     32'd1);
    chk("eq_busy",  32'(busy),     32'd0);
    chk("eq_valid", 32'(wr_valid), 32'd0);
    tick();
    chk("eq_done2",  32'(done),     32'd0);
    chk("eq_valid2", 32'(wr_valid), 32'd0);

    // Mid-ramp SPI write of 0x80 while ramping 0x55 -> 0xFF, step 0x10, interval 2.
    start(8'hFF, 8'h10, 16'd2);
    for (int k = 0; k <= 9; k++) begin
      tick();
      clr();
      if (k == 5) begin
        chk("mid_first_valid", 32'(wr_valid), 32'd1);
        chk("mid_first_data",  32'(wr_data),  32'h65);
        spi(1'b1, 7'h04, 8'h80);
      end
      if (k == 6) chk("mid_spi_duty", 32'(duty_cur), 32'h80);
`ifdef PWM_RAMP_OVERRIDE_EN
      if (k == 6) chk("ovr_busy", 32'(busy), 32'd0);
      if (k >= 7) chk("ovr_no_write", 32'(wr_valid), 32'd0);
`else
      if (k == 6) chk("mid_busy", 32'(busy), 32'd1);
      if (k == 7 || k == 8) chk("mid_gap", 32'(wr_valid), 32'd0);
      if (k == 9) begin
        chk("mid_next_valid", 32'(wr_valid), 32'd1);
        chk("mid_next_data",  32'(wr_data),  32'h90);
      end
`endif
    end

    // Reset while waiting between steps.
    rst = 1'b1;
    tick();
    chk_reset_vals("rst_wait");
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rst_wait_quiet", 32'(wr_valid), 32'd0);
    end

    // Reset on the cycle the ramp is in WRITE.
    start(8'h40, 8'd1, 16'd0);
    tick(); clr();
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_reset_vals("rst_write");
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rst_write_quiet", 32'(wr_valid), 32'd0);
    end
    chk("rst_write_duty", 32'(duty_cur), 32'd0);
    chk("rst_write_busy", 32'(busy),     32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
